// File: rtl/bus_response_mux.sv
// -----------------------------------------------------------------------------
// bus_response_mux
//
// Routes a single-master read request to one of eight slaves and returns the
// selected slave's response (or an error) to the master.
//
// The top SLAVE_ADDR_WIDTH bits of m_addr pick the slave. The selected slave
// sees a one-hot s_req for as long as the transaction is outstanding. The
// master gets exactly one m_rdy pulse per accepted request. The pulse carries
// one of three results:
//   - the slave's read data with m_err=0, when s_rdy[idx] arrives in time;
//   - zero data with m_err=1, when TIMEOUT cycles pass without s_rdy[idx];
//   - zero data with m_err=1, one cycle after the request, when the addressed
//     slave is absent from SLAVE_EN.
//
// Parameters
//   ADDR_WIDTH        master address width
//   DATA_WIDTH        read-data width per slave
//   SLAVE_ADDR_WIDTH  number of top address bits used as the slave index
//   TIMEOUT           WAIT cycles before an error response (2..255)
//   SLAVE_EN          per-slave present mask, bit k = slave k exists
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   m_req      in   master request, sampled only in IDLE
//   m_addr     in   master address, sampled with m_req
//   m_rdy      out  one-cycle response strobe
//   m_err      out  error qualifier (zero unless m_rdy)
//   m_rd_data  out  response data (zero unless m_rdy)
//   s_req      out  one-hot request to the selected slave (WAIT only)
//   s_rdy      in   per-slave ready/done; only the selected bit is observed
//   s_rd_data  in   packed slave read data, slave k at [k*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module bus_response_mux #(
  parameter int          ADDR_WIDTH       = 32,
  parameter int          DATA_WIDTH       = 32,
  parameter int          SLAVE_ADDR_WIDTH = 3,
  parameter int          TIMEOUT          = 16,
  parameter logic [7:0]  SLAVE_EN         = 8'hFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_req,
  input  logic [ADDR_WIDTH-1:0]   m_addr,
  output logic                    m_rdy,
  output logic                    m_err,
  output logic [DATA_WIDTH-1:0]   m_rd_data,
  output logic [7:0]              s_req,
  input  logic [7:0]              s_rdy,
  input  logic [8*DATA_WIDTH-1:0] s_rd_data
);

  localparam int         NUM_SLAVES = 8;
  localparam int         CNT_W      = 8;
  // Last WAIT cycle in which a missing ready turns into a timeout.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t                      state_q, state_d;
  logic [SLAVE_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]       s_req_q, s_req_d;
  logic                        m_rdy_q, m_rdy_d;
  logic                        m_err_q, m_err_d;
  logic [DATA_WIDTH-1:0]       m_rd_data_q, m_rd_data_d;

  // ---------------------------------------------------------------------------
  // Slave-side unpacking and request decode
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]       slice_data [NUM_SLAVES];
  logic [SLAVE_ADDR_WIDTH-1:0] req_idx;
  logic [NUM_SLAVES-1:0]       req_onehot;
  logic                        req_present;
  logic                        sel_rdy;
  logic [DATA_WIDTH-1:0]       sel_data;
  logic                        timeout_hit;

  // Low address bits carry no routing information for this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^m_addr[ADDR_WIDTH-SLAVE_ADDR_WIDTH-1:0];

  assign req_idx     = m_addr[ADDR_WIDTH-1 -: SLAVE_ADDR_WIDTH];
  assign req_present = SLAVE_EN[req_idx];

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
    assign slice_data[gi] = s_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_onehot[gi] = (req_idx == SLAVE_ADDR_WIDTH'(gi));
  end

  // Only the captured slave's ready and data are ever looked at; ready from
  // any other slave is ignored by construction.
  assign sel_rdy     = s_rdy[idx_q];
  assign sel_data    = slice_data[idx_q];
  assign timeout_hit = (cnt_q == TO_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  //   Output registers default to zero so m_rdy/m_err/m_rd_data and s_req
  //   are only nonzero in the cycle(s) that explicitly set them.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    s_req_d     = '0;
    m_rdy_d     = 1'b0;
    m_err_d     = 1'b0;
    m_rd_data_d = '0;

    case (state_q)
      IDLE: begin
        if (m_req) begin
          idx_d = req_idx;
          if (req_present) begin
            state_d = WAIT;
            s_req_d = req_onehot;
            cnt_d   = '0;
          end else begin
            // Absent slave: answer with an error right away, never touch s_req.
            state_d = RESP;
            m_rdy_d = 1'b1;
            m_err_d = 1'b1;
          end
        end
      end

      WAIT: begin
        // Ready is checked before the timeout so a ready arriving in the
        // last allowed cycle still returns data.
        if (sel_rdy) begin
          state_d     = RESP;
          m_rdy_d     = 1'b1;
          m_rd_data_d = sel_data;
          cnt_d       = '0;
        end else if (timeout_hit) begin
          state_d = RESP;
          m_rdy_d = 1'b1;
          m_err_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          s_req_d = s_req_q;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      s_req_q     <= '0;
      m_rdy_q     <= 1'b0;
      m_err_q     <= 1'b0;
      m_rd_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      s_req_q     <= s_req_d;
      m_rdy_q     <= m_rdy_d;
      m_err_q     <= m_err_d;
      m_rd_data_q <= m_rd_data_d;
    end
  end

  assign m_rdy     = m_rdy_q;
  assign m_err     = m_err_q;
  assign m_rd_data = m_rd_data_q;
  assign s_req     = s_req_q;

endmodule

// File: tb/tb_bus_response_mux.sv
// -----------------------------------------------------------------------------
// tb_bus_response_mux
//
// Two instances share address and slave-side stimulus: dut uses the default
// slave mask, dut_b has slave 7 absent. Stimulus pushes the expected response
// (cycle, error, data) into a per-instance queue; independent monitors pop and
// compare whenever m_rdy is seen. Cycle numbers follow the cyc counter, which
// advances on every rising edge.
// -----------------------------------------------------------------------------
module tb_bus_response_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_req, m_req_b;
  logic [31:0]  m_addr;
  logic [7:0]   s_rdy;
  logic [255:0] s_rd_data;

  logic         m_rdy, m_err, m_rdy_b, m_err_b;
  logic [31:0]  m_rd_data, m_rd_data_b;
  logic [7:0]   s_req, s_req_b;

  always #5 clk = ~clk;

  bus_response_mux #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SLAVE_ADDR_WIDTH(3),
    .TIMEOUT(16), .SLAVE_EN(8'hFF)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr),
    .m_rdy(m_rdy), .m_err(m_err), .m_rd_data(m_rd_data),
    .s_req(s_req), .s_rdy(s_rdy), .s_rd_data(s_rd_data)
  );

  bus_response_mux #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SLAVE_ADDR_WIDTH(3),
    .TIMEOUT(16), .SLAVE_EN(8'h7F)
  ) dut_b (
    .clk(clk), .rst(rst), .m_req(m_req_b), .m_addr(m_addr),
    .m_rdy(m_rdy_b), .m_err(m_err_b), .m_rd_data(m_rd_data_b),
    .s_req(s_req_b), .s_rdy(s_rdy), .s_rd_data(s_rd_data)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_q_b[$];
  exp_t e_a, e_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (m_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_rdy: m_rdy=1 err=%0b data=%h at cycle %0d, expected no response",
                 m_err, m_rd_data, cyc);
      end else begin
        e_a = exp_q.pop_front();
        $display("txn %s: cycle %0d err %0b data %h", e_a.name, cyc, m_err, m_rd_data);
        check({e_a.name, "_cycle"}, 64'(cyc), 64'(e_a.cyc));
        check({e_a.name, "_err"}, 64'(m_err), 64'(e_a.err));
        check({e_a.name, "_data"}, 64'(m_rd_data), 64'(e_a.data));
      end
    end else begin
      check("idle_outputs_zero", 64'({m_err, m_rd_data}), 64'd0);
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e_a = exp_q.pop_front();
        check({e_a.name, "_missing_rdy"}, 64'(cyc), 64'(e_a.cyc));
      end
    end
    check("s_req_onehot0", 64'($onehot0(s_req)), 64'd1);
  end

  always @(negedge clk) begin
    if (m_rdy_b === 1'b1) begin
      if (exp_q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_rdy_b: m_rdy=1 err=%0b data=%h at cycle %0d, expected no response",
                 m_err_b, m_rd_data_b, cyc);
      end else begin
        e_b = exp_q_b.pop_front();
        $display("txn %s: cycle %0d err %0b data %h", e_b.name, cyc, m_err_b, m_rd_data_b);
        check({e_b.name, "_cycle"}, 64'(cyc), 64'(e_b.cyc));
        check({e_b.name, "_err"}, 64'(m_err_b), 64'(e_b.err));
        check({e_b.name, "_data"}, 64'(m_rd_data_b), 64'(e_b.data));
      end
    end else begin
      check("idle_outputs_zero_b", 64'({m_err_b, m_rd_data_b}), 64'd0);
      if (exp_q_b.size() != 0 && exp_q_b[0].cyc < cyc) begin
        e_b = exp_q_b.pop_front();
        check({e_b.name, "_missing_rdy"}, 64'(cyc), 64'(e_b.cyc));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int k, input logic [31:0] val);
    s_rd_data[k*32 +: 32] = val;
  endtask

  function automatic exp_t mk(input int c, input logic err, input logic [31:0] data, input string name);
    exp_t e;
    e.cyc  = c;
    e.err  = err;
    e.data = data;
    e.name = name;
    return e;
  endfunction

  // Present a request for one cycle; n returns the request cycle.
  task automatic issue(input logic [31:0] addr, output int n);
    m_addr = addr;
    m_req  = 1'b1;
    n      = cyc;
    tick();
    m_req  = 1'b0;
  endtask

  // Normal read: selected slave answers k cycles after s_req first appears.
  task automatic read(input string name, input logic [31:0] addr, input int k,
                      input logic [31:0] data);
    int         n;
    logic [2:0] idx;
    logic [7:0] onehot;
    idx    = addr[31:29];
    onehot = 8'h01 << idx;
    set_slice(int'(idx), data);
    issue(addr, n);
    exp_q.push_back(mk(n + 2 + k, 1'b0, data, name));
    check({name, "_s_req_first"}, 64'(s_req), 64'(onehot));
    repeat (k) tick();
    check({name, "_s_req_held"}, 64'(s_req), 64'(onehot));
    s_rdy[idx] = 1'b1;
    tick();
    s_rdy = 8'h00;
    check({name, "_s_req_resp"}, 64'(s_req), 64'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst     = 1'b1;
    m_req   = 1'b0;
    m_req_b = 1'b0;
    m_addr  = '0;
    s_rdy   = 8'h00;
    s_rd_data = '0;
    for (int k = 0; k < 8; k++) set_slice(k, 32'hA5A5_0000 | 32'(k));

    repeat (3) tick();
    check("reset_outputs", 64'({m_rdy, m_err, m_rd_data, s_req}), 64'd0);
    check("reset_outputs_b", 64'({m_rdy_b, m_err_b, m_rd_data_b, s_req_b}), 64'd0);
    rst = 1'b0;
    tick();

    // Normal read, slave 2, ready 3 cycles after s_req.
    read("normal_read", 32'h4000_0010, 3, 32'hDEAD_BEEF);

    // Timeout on slave 7: s_req held for 16 cycles, then error.
    issue(32'hE000_0000, n);
    exp_q.push_back(mk(n + 17, 1'b1, 32'h0, "timeout"));
    check("timeout_s_req_first", 64'(s_req), 64'h80);
    repeat (15) tick();
    check("timeout_s_req_last", 64'(s_req), 64'h80);
    tick();
    check("timeout_s_req_resp", 64'(s_req), 64'd0);
    tick();

    // Ready in the final allowed WAIT cycle beats the timeout.
    read("boundary_race", 32'hE000_0004, 15, 32'h7777_0015);

    // Minimum latency read.
    read("min_latency", 32'hA000_0000, 0, 32'h5555_AAAA);

    // Wrong-slave ready is ignored; later correct ready completes.
    set_slice(0, 32'h0BAD_0BAD);
    set_slice(1, 32'h1111_2222);
    issue(32'h2000_0000, n);
    exp_q.push_back(mk(n + 6, 1'b0, 32'h1111_2222, "wrong_slave"));
    tick();
    s_rdy = 8'h01;
    tick();
    s_rdy = 8'hFD;
    check("wrong_slave_s_req", 64'(s_req), 64'h02);
    tick();
    s_rdy = 8'h00;
    tick();
    s_rdy = 8'h02;
    tick();
    s_rdy = 8'h00;
    tick();

    // Request held across RESP is accepted again in the next IDLE cycle.
    set_slice(4, 32'h4444_0001);
    m_addr = 32'h8000_0000;
    m_req  = 1'b1;
    n      = cyc;
    exp_q.push_back(mk(n + 2, 1'b0, 32'h4444_0001, "held_first"));
    exp_q.push_back(mk(n + 5, 1'b0, 32'h4444_0001, "held_second"));
    tick();
    s_rdy = 8'h10;
    tick();
    s_rdy = 8'h00;
    tick();
    tick();
    m_req = 1'b0;
    check("held_second_s_req", 64'(s_req), 64'h10);
    s_rdy = 8'h10;
    tick();
    s_rdy = 8'h00;
    tick();

    // Reset on WAIT cycle 2, with ready and request present: no response.
    issue(32'h6000_0000, n);
    tick();
    tick();
    check("rst_wait_s_req_before", 64'(s_req), 64'h08);
    rst   = 1'b1;
    s_rdy = 8'h08;
    m_req = 1'b1;
    tick();
    check("rst_wait_s_req_after", 64'(s_req), 64'd0);
    check("rst_wait_no_rdy", 64'({m_rdy, m_err, m_rd_data}), 64'd0);
    rst   = 1'b0;
    s_rdy = 8'h00;
    m_req = 1'b0;
    tick();
    read("after_reset", 32'h6000_0008, 1, 32'h3333_CAFE);

    // Absent slave on dut_b: error one cycle after the request, no s_req.
    m_addr  = 32'hE000_0000;
    m_req_b = 1'b1;
    n       = cyc;
    exp_q_b.push_back(mk(n + 1, 1'b1, 32'h0, "disabled_slave"));
    tick();
    m_req_b = 1'b0;
    check("disabled_s_req", 64'(s_req_b), 64'd0);
    tick();
    check("disabled_s_req_after", 64'(s_req_b), 64'd0);

    // Present slave on dut_b still works normally.
    m_addr  = 32'h0000_0000;
    m_req_b = 1'b1;
    n       = cyc;
    exp_q_b.push_back(mk(n + 2, 1'b0, 32'h0BAD_0BAD, "b_enabled"));
    tick();
    m_req_b = 1'b0;
    check("b_enabled_s_req", 64'(s_req_b), 64'h01);
    s_rdy = 8'h01;
    tick();
    s_rdy = 8'h00;
    tick();

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size() + exp_q_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
